instr_mem_fetch: RTL and testbench
==================================

Name: instr_mem_fetch

Overview:
Parametrised, loadable instruction memory with a pipelined fetch port for the MIPS core.
- Replaces the fixed combinational instruction ROM.
- A program is streamed in over a sequential load port.
- Fetches are accepted one per cycle and answered after RD_LAT cycles.
- End-of-program is derived from the loaded program length, not a hard-coded address.

Parameters:
DATA_W, 32, instruction word width
ADDR_W, 30, word-address width of fetch_addr (byte address >> 2)
DEPTH, 256, number of storage words (power of 2, ≤ 2**ADDR_W)
RD_LAT, 1, fetch-to-response latency in cycles, legal values 1 or 2
NOP_WORD, 0, word returned for out-of-range fetches

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
load_start  in  1  pulse: discard current program, enter LOAD
load_valid  in  1  load_data beat valid
load_data  in  DATA_W  instruction word to store at next sequential address
load_last  in  1  marks final beat of program (qualified by load_valid)
load_ready  out  1  memory can accept a load beat
fetch_req  in  1  fetch request
fetch_addr  in  ADDR_W  word address of requested instruction
fetch_ready  out  1  fetch_req accepted this cycle when both high
stall  in  1  freezes fetch pipeline and holds outputs
instr_valid  out  1  response valid
instruction  out  DATA_W  fetched word
instr_addr  out  ADDR_W  address belonging to instruction
mem_end  out  1  response address ≥ prog_len (qualified by instr_valid)
prog_len  out  clog2(DEPTH)+1  number of words loaded
busy  out  1  state is LOAD

Behaviour:
- Reset (async, rst_n=0):
  - Control outputs: state=EMPTY, prog_len=0, load_ptr=0, instr_valid=0, instruction=NOP_WORD, instr_addr=0, mem_end=0, load_ready=0, fetch_ready=0, busy=0.
  - Storage array is not reset.
- FSM states: EMPTY, LOAD, READY.
  - EMPTY --load_start--> LOAD.
  - LOAD --(load_valid & load_ready & load_last)--> READY.
  - READY --load_start--> LOAD.
  - load_start in LOAD restarts the load: load_ptr=0, prog_len=0.
- Load:
  - On entering LOAD: load_ptr=0, prog_len=0.
  - load_ready = (state==LOAD) & (load_ptr<DEPTH).
  - Each accepted beat writes mem[load_ptr], then load_ptr++ and prog_len++.
  - Full (load_ptr==DEPTH): load_ready=0. Extra beats are ignored and the program truncates at DEPTH. A load_last beat arriving while full is not accepted and does not complete the load, so the loader must end the program within DEPTH beats.
  - No wrap-around.
- Fetch:
  - fetch_ready = (state==READY) & ~load_start & ~stall.
  - Accepted request issues at most one per cycle.
  - Response is presented after RD_LAT rising edges:
    - RD_LAT=1: synchronous RAM read.
    - RD_LAT=2: additional output register stage.
  - Response fields: instr_valid=1, instr_addr=fetch_addr, instruction = (fetch_addr<prog_len) ? mem[fetch_addr] : NOP_WORD, mem_end = (fetch_addr ≥ prog_len).
  - Addresses ≥ DEPTH are out of range even if upper bits alias; never index mem with them.
  - Cycle without an accepted request: next-stage instr_valid=0, other response fields hold.
- Stall: all pipeline registers hold; response outputs remain stable; fetch_ready=0.
- Simultaneous events:
  - load_start with fetch_req: load_start wins, fetch not accepted.
  - load_start flushes all in-flight responses: instr_valid=0 from the next cycle. Flush overrides stall.
- Fetching a just-loaded address in the cycle READY is entered is legal; the write has already completed.
- Reset mid-load: returns to EMPTY, prog_len=0; the partial program is unusable.

Decomposition:
- Shared package instr_mem_pkg holds:
  - FSM state encoding: ST_EMPTY, ST_LOAD, ST_READY.
  - NOP_WORD default.
  - Localparam PTR_W = clog2(DEPTH)+1.
- One natural sub-module: instr_mem_ram. Single-port-write / single-port-read synchronous RAM, DEPTH×DATA_W, registered read data with hold enable for stall.
- FSM, load pointer and latency pipeline remain in instr_mem_fetch.

Test Plan:
- Load 3 words 0x20050005, 0x20060001, 0x00A62022 (load_last on 3rd), then fetch 0,1,2 back-to-back -> prog_len=3. With RD_LAT=1, responses on consecutive cycles 1 cycle after each request, matching words, instr_addr 0,1,2, mem_end=0.
- After the 3-word load, fetch address 3 and 0x3FFFFFFF -> instruction=0, mem_end=1, instr_valid=1.
- RD_LAT=2, fetch 0 then assert stall for 3 cycles mid-flight -> response appears 2 unstalled cycles after the request; outputs constant during stall; no lost or duplicated beats.
- Load DEPTH+4 beats with load_last on the final one -> load_ready drops after DEPTH beats, prog_len=DEPTH, FSM stays in LOAD. Then load_start and a 2-word load -> READY, prog_len=2.
- In READY, fetch 1 with load_start on the next cycle -> in-flight response suppressed (instr_valid stays 0), busy=1, fetch_ready=0.
- Assert rst_n=0 asynchronously mid-load after 5 beats -> outputs return to reset values immediately; state EMPTY; fetch_ready=0 until a new load completes.

Source files
------------

// File: rtl/instr_mem_pkg.sv
// Shared definitions for the loadable instruction memory with pipelined fetch.
// Holds the FSM state encoding, the default out-of-range instruction word,
// the default storage depth and the helper that sizes the load pointer and
// program-length counters (clog2(DEPTH)+1 bits, so DEPTH itself is representable).
package instr_mem_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_LOAD  = 2'd1,
    ST_READY = 2'd2
  } state_e;

  localparam int unsigned  DEFAULT_DEPTH    = 256;
  localparam logic [31:0]  NOP_WORD_DEFAULT = 32'h0000_0000;

  // Width of a counter that must hold every value 0..depth inclusive.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/instr_mem_ram.sv
// Synchronous instruction storage: one write port, one read port, DEPTH x DATA_W.
// Read data is registered; the register only updates when re_i is high, so it
// holds its value while the fetch pipeline is stalled or idle.
// Ports:
//   clk, rst_n         clock, async active-low reset (read register only)
//   we_i/waddr_i/wdata_i   write strobe, word index, data
//   re_i/raddr_i       read strobe, word index
//   rdata_o            registered read data (RST_WORD after reset)
module instr_mem_ram
  import instr_mem_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = DEFAULT_DEPTH,
  parameter logic [DATA_W-1:0] RST_WORD = DATA_W'(NOP_WORD_DEFAULT)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [DATA_W-1:0]        wdata_i,
  input  logic                     re_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [DATA_W-1:0]        rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // NOTE: the storage array has no reset so it maps onto block RAM; its
  // contents are only meaningful below the loaded program length.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    rdata_q <= RST_WORD;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/instr_mem_fetch.sv
// Loadable instruction memory with a pipelined fetch port.
// A program is streamed in over the load port (EMPTY/LOAD/READY FSM); fetches
// are accepted one per cycle in READY and answered RD_LAT (1 or 2) unstalled
// cycles later. Addresses at or beyond the loaded length return NOP_WORD with
// mem_end_o set.
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   load_start_i                       restart loading (flushes fetches)
//   load_valid_i/load_data_i/load_last_i/load_ready_o   load beat handshake
//   fetch_req_i/fetch_addr_i/fetch_ready_o               fetch handshake
//   stall_i                            freeze fetch pipeline
//   instr_valid_o/instruction_o/instr_addr_o/mem_end_o   fetch response
//   prog_len_o                         words loaded, busy_o  loading in progress
module instr_mem_fetch
  import instr_mem_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 30,
  parameter int                DEPTH    = DEFAULT_DEPTH,
  parameter int                RD_LAT   = 1,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_WORD_DEFAULT)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load_start_i,
  input  logic                     load_valid_i,
  input  logic [DATA_W-1:0]        load_data_i,
  input  logic                     load_last_i,
  output logic                     load_ready_o,
  input  logic                     fetch_req_i,
  input  logic [ADDR_W-1:0]        fetch_addr_i,
  output logic                     fetch_ready_o,
  input  logic                     stall_i,
  output logic                     instr_valid_o,
  output logic [DATA_W-1:0]        instruction_o,
  output logic [ADDR_W-1:0]        instr_addr_o,
  output logic                     mem_end_o,
  output logic [$clog2(DEPTH):0]   prog_len_o,
  output logic                     busy_o
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CMP_W = (ADDR_W >= PTR_W) ? ADDR_W : PTR_W;

  state_e            state_q, state_d;
  logic [PTR_W-1:0]  load_ptr_q, load_ptr_d;
  logic              load_beat;
  logic              fetch_acc;
  logic              in_range;
  logic [CMP_W-1:0]  addr_cmp, len_cmp;
  logic [DATA_W-1:0] ram_rdata;

  // Stage 1 follows the RAM read register.
  logic              s1_valid_q;
  logic [ADDR_W-1:0] s1_addr_q;
  logic              s1_end_q;
  logic [DATA_W-1:0] s1_instr;

  // ---------------------------------------------------------------- load side
  assign busy_o       = (state_q == ST_LOAD);
  assign load_ready_o = busy_o && (load_ptr_q < PTR_W'(DEPTH));
  // load_start takes priority over a beat presented in the same cycle.
  assign load_beat    = load_valid_i && load_ready_o && !load_start_i;

  // Words are written strictly sequentially from 0, so the load pointer is
  // also the program length.
  assign prog_len_o   = load_ptr_q;

  // NOTE: every signal assigned here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    load_ptr_d = load_ptr_q;
    if (load_start_i) begin
      state_d    = ST_LOAD;
      load_ptr_d = '0;
    end else if (load_beat) begin
      load_ptr_d = load_ptr_q + PTR_W'(1);
      if (load_last_i) state_d = ST_READY;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      load_ptr_q <= '0;
    end else begin
      state_q    <= state_d;
      load_ptr_q <= load_ptr_d;
    end
  end

  // --------------------------------------------------------------- fetch side
  assign fetch_ready_o = (state_q == ST_READY) && !load_start_i && !stall_i;
  assign fetch_acc     = fetch_req_i && fetch_ready_o;

  // Compare at full address width so aliased upper bits never look in range.
  assign addr_cmp = CMP_W'(fetch_addr_i);
  assign len_cmp  = CMP_W'(load_ptr_q);
  assign in_range = (addr_cmp < len_cmp);

  instr_mem_ram #(
    .DATA_W  (DATA_W),
    .DEPTH   (DEPTH),
    .RST_WORD(NOP_WORD)
  ) u_ram (
    .clk    (clk),
    .rst_n  (rst_n),
    .we_i   (load_beat),
    .waddr_i(load_ptr_q[IDX_W-1:0]),
    .wdata_i(load_data_i),
    .re_i   (fetch_acc && in_range),
    .raddr_i(fetch_addr_i[IDX_W-1:0]),
    .rdata_o(ram_rdata)
  );

  // load_start flushes even when stalled; otherwise stall freezes the stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_addr_q  <= '0;
      s1_end_q   <= 1'b0;
    end else if (load_start_i) begin
      s1_valid_q <= 1'b0;
    end else if (!stall_i) begin
      s1_valid_q <= fetch_acc;
      if (fetch_acc) begin
        s1_addr_q <= fetch_addr_i;
        s1_end_q  <= !in_range;
      end
    end
  end

  // Out-of-range fetches leave the RAM register untouched; substitute here.
  assign s1_instr = s1_end_q ? NOP_WORD : ram_rdata;

  if (RD_LAT == 2) begin : g_out_reg
    logic              s2_valid_q;
    logic [ADDR_W-1:0] s2_addr_q;
    logic              s2_end_q;
    logic [DATA_W-1:0] s2_instr_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s2_valid_q <= 1'b0;
        s2_addr_q  <= '0;
        s2_end_q   <= 1'b0;
        s2_instr_q <= NOP_WORD;
      end else if (load_start_i) begin
        s2_valid_q <= 1'b0;
      end else if (!stall_i) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_addr_q  <= s1_addr_q;
          s2_end_q   <= s1_end_q;
          s2_instr_q <= s1_instr;
        end
      end
    end

    assign instr_valid_o = s2_valid_q;
    assign instr_addr_o  = s2_addr_q;
    assign mem_end_o     = s2_end_q;
    assign instruction_o = s2_instr_q;
  end else begin : g_no_out_reg
    assign instr_valid_o = s1_valid_q;
    assign instr_addr_o  = s1_addr_q;
    assign mem_end_o     = s1_end_q;
    assign instruction_o = s1_instr;
  end

endmodule

// File: tb/tb_instr_mem_fetch.sv
// Bench for instr_mem_fetch: two instances (RD_LAT=1 and RD_LAT=2) share one
// stimulus stream. A behavioural model (program array + list of outstanding
// fetches aged in unstalled cycles) predicts every output and is compared on
// each falling edge; directed steps add literal expectations.
module tb_instr_mem_fetch;

  localparam int          DEPTH = 16;
  localparam logic [31:0] NOP   = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        load_start = 1'b0, load_valid = 1'b0, load_last = 1'b0;
  logic [31:0] load_data = '0;
  logic        fetch_req = 1'b0, stall = 1'b0;
  logic [29:0] fetch_addr = '0;

  logic        lr1, fr1, iv1, me1, busy1, lr2, fr2, iv2, me2, busy2;
  logic [31:0] ins1, ins2;
  logic [29:0] ia1, ia2;
  logic [4:0]  pl1, pl2;

  instr_mem_fetch #(.DATA_W(32), .ADDR_W(30), .DEPTH(DEPTH), .RD_LAT(1), .NOP_WORD(NOP)) u1 (
    .clk(clk), .rst_n(rst_n), .load_start_i(load_start), .load_valid_i(load_valid),
    .load_data_i(load_data), .load_last_i(load_last), .load_ready_o(lr1),
    .fetch_req_i(fetch_req), .fetch_addr_i(fetch_addr), .fetch_ready_o(fr1), .stall_i(stall),
    .instr_valid_o(iv1), .instruction_o(ins1), .instr_addr_o(ia1), .mem_end_o(me1),
    .prog_len_o(pl1), .busy_o(busy1));

  instr_mem_fetch #(.DATA_W(32), .ADDR_W(30), .DEPTH(DEPTH), .RD_LAT(2), .NOP_WORD(NOP)) u2 (
    .clk(clk), .rst_n(rst_n), .load_start_i(load_start), .load_valid_i(load_valid),
    .load_data_i(load_data), .load_last_i(load_last), .load_ready_o(lr2),
    .fetch_req_i(fetch_req), .fetch_addr_i(fetch_addr), .fetch_ready_o(fr2), .stall_i(stall),
    .instr_valid_o(iv2), .instruction_o(ins2), .instr_addr_o(ia2), .mem_end_o(me2),
    .prog_len_o(pl2), .busy_o(busy2));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------ model
  typedef struct {
    logic [29:0] addr;
    logic [31:0] word;
    bit          endf;
    int          age;
  } resp_t;

  resp_t       pend[$];
  int          m_mode = 0;  // 0 empty, 1 loading, 2 ready
  int          m_len  = 0;
  logic [31:0] m_mem [DEPTH];
  bit          e_valid [2];
  logic [29:0] e_addr  [2];
  logic [31:0] e_instr [2];
  bit          e_end   [2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0;
      m_len  = 0;
      pend.delete();
      for (int k = 0; k < 2; k++) begin
        e_valid[k] = 1'b0; e_addr[k] = '0; e_instr[k] = NOP; e_end[k] = 1'b0;
      end
    end else begin
      bit    acc;
      resp_t r;
      acc = fetch_req && (m_mode == 2) && !load_start && !stall;
      if (load_start) begin
        pend.delete();
        e_valid[0] = 1'b0;
        e_valid[1] = 1'b0;
      end else if (!stall) begin
        foreach (pend[j]) pend[j].age++;
        if (acc) begin
          r.addr = fetch_addr;
          r.endf = (fetch_addr >= m_len);
          if (r.endf) r.word = NOP;
          else        r.word = m_mem[fetch_addr];
          r.age = 1;
          pend.push_back(r);
        end
        for (int k = 0; k < 2; k++) begin
          e_valid[k] = 1'b0;
          foreach (pend[j]) begin
            if (pend[j].age == k + 1) begin
              e_valid[k] = 1'b1;
              e_addr[k]  = pend[j].addr;
              e_instr[k] = pend[j].word;
              e_end[k]   = pend[j].endf;
            end
          end
        end
        while (pend.size() > 0 && pend[0].age >= 2) void'(pend.pop_front());
      end
      if (load_start) begin
        m_mode = 1;
        m_len  = 0;
      end else if (m_mode == 1 && load_valid && m_len < DEPTH) begin
        m_mem[m_len] = load_data;
        m_len++;
        if (load_last) m_mode = 2;
      end
    end
  end

  task automatic cmp_dut(input int k, input logic iv, input logic [31:0] ins, input logic [29:0] ia,
                         input logic me, input logic [4:0] pl, input logic busy,
                         input logic lr, input logic fr);
    string p;
    p = $sformatf("u%0d.", k + 1);
    check({p, "instr_valid"}, iv,   e_valid[k]);
    check({p, "instruction"}, ins,  e_instr[k]);
    check({p, "instr_addr"},  ia,   e_addr[k]);
    check({p, "mem_end"},     me,   e_end[k]);
    check({p, "prog_len"},    pl,   m_len);
    check({p, "busy"},        busy, m_mode == 1);
    check({p, "load_ready"},  lr,   (m_mode == 1) && (m_len < DEPTH));
    check({p, "fetch_ready"}, fr,   (m_mode == 2) && !load_start && !stall);
  endtask

  always @(negedge clk) begin
    cmp_dut(0, iv1, ins1, ia1, me1, pl1, busy1, lr1, fr1);
    cmp_dut(1, iv2, ins2, ia2, me2, pl2, busy2, lr2, fr2);
  end

  // ------------------------------------------------------------ stimulus
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] prog3 [3] = '{32'h2005_0005, 32'h2006_0001, 32'h00A6_2022};
  logic [29:0] oor   [3] = '{30'd3, 30'h3FFF_FFFF, 30'd17};

  initial begin
    // Asynchronous reset before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    check("rst.u1.instr_valid", iv1, 0);
    check("rst.u2.instr_valid", iv2, 0);
    check("rst.u1.instruction", ins1, NOP);
    check("rst.u2.instruction", ins2, NOP);
    check("rst.u1.prog_len", pl1, 0);
    check("rst.u1.busy", busy1, 0);
    check("rst.u1.load_ready", lr1, 0);
    check("rst.u1.fetch_ready", fr1, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Fetch while EMPTY is refused.
    fetch_req = 1'b1; fetch_addr = '0;
    #1 check("empty.fetch_ready", fr1, 0);
    tick();
    fetch_req = 1'b0;

    // Three-word program.
    load_start = 1'b1; tick(); load_start = 1'b0;
    check("load3.busy", busy1, 1);
    check("load3.load_ready", lr1, 1);
    for (int i = 0; i < 3; i++) begin
      load_valid = 1'b1; load_data = prog3[i]; load_last = (i == 2);
      tick();
    end
    load_valid = 1'b0; load_last = 1'b0;
    check("load3.prog_len", pl1, 3);
    check("load3.busy_after", busy1, 0);

    // Back-to-back fetches 0,1,2.
    for (int i = 0; i < 3; i++) begin
      fetch_req = 1'b1; fetch_addr = 30'(i);
      tick();
      check($sformatf("fetch%0d.u1.valid", i), iv1, 1);
      check($sformatf("fetch%0d.u1.instr", i), ins1, prog3[i]);
      check($sformatf("fetch%0d.u1.addr", i), ia1, i);
      check($sformatf("fetch%0d.u1.end", i), me1, 0);
      if (i > 0) check($sformatf("fetch%0d.u2.instr", i), ins2, prog3[i-1]);
    end
    fetch_req = 1'b0;
    tick();
    check("fetch.u2.last_instr", ins2, prog3[2]);
    check("fetch.u1.idle_valid", iv1, 0);

    // Out-of-range fetches, including aliased upper bits.
    for (int i = 0; i < 3; i++) begin
      fetch_req = 1'b1; fetch_addr = oor[i];
      tick();
      check($sformatf("oor%0d.valid", i), iv1, 1);
      check($sformatf("oor%0d.instr", i), ins1, NOP);
      check($sformatf("oor%0d.end", i), me1, 1);
      check($sformatf("oor%0d.addr", i), ia1, oor[i]);
    end
    fetch_req = 1'b0;
    tick(); tick();

    // Stall mid-flight on the two-cycle instance.
    fetch_req = 1'b1; fetch_addr = 30'd0;
    tick();
    check("stall.u2.pre_valid", iv2, 0);
    stall = 1'b1; fetch_addr = 30'd2;
    #1 check("stall.fetch_ready", fr1, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("stall%0d.u2.valid", i), iv2, 0);
      check($sformatf("stall%0d.u1.hold", i), ins1, prog3[0]);
    end
    stall = 1'b0; fetch_req = 1'b0;
    tick();
    check("unstall.u2.valid", iv2, 1);
    check("unstall.u2.instr", ins2, prog3[0]);
    tick();
    check("unstall.u2.no_dup", iv2, 0);

    // load_start flushes an in-flight response and beats a same-cycle fetch.
    fetch_req = 1'b1; fetch_addr = 30'd1;
    tick();
    fetch_addr = 30'd2; load_start = 1'b1;
    tick();
    check("flush.u2.valid", iv2, 0);
    check("flush.u1.valid", iv1, 0);
    check("flush.u1.addr", ia1, 1);
    check("flush.busy", busy1, 1);
    check("flush.fetch_ready", fr1, 0);
    load_start = 1'b0; fetch_req = 1'b0;
    tick();
    check("flush.u2.still0", iv2, 0);

    // Overflow: DEPTH+4 beats, last on the final (refused) beat.
    for (int i = 0; i < DEPTH + 4; i++) begin
      load_valid = 1'b1; load_data = 32'hA000_0000 + 32'(i); load_last = (i == DEPTH + 3);
      tick();
    end
    check("ovf.prog_len", pl1, DEPTH);
    check("ovf.busy", busy1, 1);
    check("ovf.load_ready", lr1, 0);
    load_valid = 1'b0; load_last = 1'b0;
    load_start = 1'b1; tick(); load_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      load_valid = 1'b1; load_data = (i == 0) ? 32'h1111_0001 : 32'h2222_0002; load_last = (i == 1);
      tick();
    end
    load_valid = 1'b0; load_last = 1'b0;
    check("reload.prog_len", pl1, 2);
    check("reload.busy", busy1, 0);
    fetch_req = 1'b1; fetch_addr = 30'd1;
    tick();
    check("reload.f1.instr", ins1, 32'h2222_0002);
    fetch_addr = 30'd2;
    tick();
    check("reload.f2.instr", ins1, NOP);
    check("reload.f2.end", me1, 1);
    fetch_req = 1'b0;
    tick();

    // Asynchronous reset in the middle of a load.
    load_start = 1'b1; tick(); load_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      load_valid = 1'b1; load_data = 32'hB000_0000 + 32'(i);
      tick();
    end
    #2 rst_n = 1'b0;
    #1;
    check("midrst.prog_len", pl1, 0);
    check("midrst.busy", busy1, 0);
    check("midrst.load_ready", lr1, 0);
    check("midrst.u2.instruction", ins2, NOP);
    check("midrst.u1.addr", ia1, 0);
    check("midrst.u1.end", me1, 0);
    load_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    fetch_req = 1'b1; fetch_addr = 30'd0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check($sformatf("postrst%0d.fetch_ready", i), fr1, 0);
    end
    load_start = 1'b1; tick(); load_start = 1'b0;
    load_valid = 1'b1; load_data = 32'hC0DE_0001; load_last = 1'b1;
    tick();
    load_valid = 1'b0; load_last = 1'b0;
    check("postrst.fetch_ready", fr1, 1);
    tick();
    check("postrst.instr", ins1, 32'hC0DE_0001);
    fetch_req = 1'b0;
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
